// File: rtl/msig_seq_pkg.sv
// Shared constants for the mixed-signal sequencer:
// FSM state codes, register offsets and bit positions.
package msig_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BIAS   = 3'd1;
  localparam logic [2:0] ST_ENABLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_SHUT   = 3'd5;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_SETTLE = 8'h04;
  localparam logic [7:0] OFF_NSAMP  = 8'h08;
  localparam logic [7:0] OFF_OEB_LO = 8'h0C;
  localparam logic [7:0] OFF_OEB_HI = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_RESULT = 8'h18;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY   = 4;
  localparam int STAT_DONE   = 5;

endpackage

// File: rtl/msig_wb_regs.sv
// Wishbone slave: decode, single-shot ack, register file,
// START/ABORT pulses and the W1C done flag.
module msig_wb_regs
  import msig_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          SETTLE_W  = 16,
  parameter int          IO_PADS   = 38
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [2:0]          state_i,
  input  logic                busy_i,
  input  logic                done_set_i,
  input  logic                done_clr_i,
  input  logic [8:0]          result_i,
  output logic                start_o,
  output logic                abort_o,
  output logic                irq_en_o,
  output logic [SETTLE_W-1:0] settle_o,
  output logic [7:0]          nsamp_o,
  output logic [IO_PADS-1:0]  oeb_o,
  output logic                done_o
);

  localparam int HI_W = IO_PADS - 32;

  logic                acc, go, wr, rd;
  logic [7:0]          off;
  logic [31:0]         rdata;
  logic                ack_q, held_q, held_d;
  logic [31:0]         dat_q, dat_d;
  logic                irq_en_q, irq_en_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [7:0]          nsamp_q, nsamp_d;
  logic [31:0]         lo_q, lo_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [IO_PADS-1:0]  oeb_q;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic                done_q, done_d;

  assign acc = wbs_stb_i & wbs_cyc_i
             & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  // held_q blocks a second ack while the same strobe lingers
  assign go  = acc & ~ack_q & ~held_q;
  assign wr  = go & wbs_we_i;
  assign rd  = go & ~wbs_we_i;
  assign off = wbs_adr_i[7:0];
  assign held_d = acc & (held_q | ack_q);

  always_comb begin
    irq_en_d = irq_en_q;
    settle_d = settle_q;
    nsamp_d  = nsamp_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    done_d   = done_q;
    if (wr) begin
      case (off)
        OFF_CTRL: if (wbs_sel_i[0]) begin
          abort_d  = wbs_dat_i[CTRL_ABORT];
          start_d  = wbs_dat_i[CTRL_START]
                   & ~wbs_dat_i[CTRL_ABORT];
          irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
        end
        OFF_SETTLE:
          for (int i = 0; i < SETTLE_W; i++)
            if (wbs_sel_i[i/8]) settle_d[i] = wbs_dat_i[i];
        OFF_NSAMP:
          if (wbs_sel_i[0]) nsamp_d = wbs_dat_i[7:0];
        OFF_OEB_LO:
          for (int i = 0; i < 32; i++)
            if (wbs_sel_i[i/8]) lo_d[i] = wbs_dat_i[i];
        OFF_OEB_HI:
          for (int i = 0; i < HI_W; i++)
            if (wbs_sel_i[i/8]) hi_d[i] = wbs_dat_i[i];
        OFF_STATUS:
          if (wbs_sel_i[0] && wbs_dat_i[STAT_DONE])
            done_d = 1'b0;
        default: ;
      endcase
    end
    if (done_clr_i) done_d = 1'b0;
    if (done_set_i) done_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
      OFF_SETTLE: rdata[SETTLE_W-1:0] = settle_q;
      OFF_NSAMP:  rdata[7:0] = nsamp_q;
      OFF_OEB_LO: rdata = lo_q;
      OFF_OEB_HI: rdata[HI_W-1:0] = hi_q;
      OFF_STATUS: begin
        rdata[2:0]       = state_i;
        rdata[STAT_BUSY] = busy_i;
        rdata[STAT_DONE] = done_q;
      end
      OFF_RESULT: rdata[8:0] = result_i;
      default: ;
    endcase
  end

  assign dat_d = rd ? rdata : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      held_q   <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      settle_q <= '0;
      nsamp_q  <= '0;
      lo_q     <= '1;
      hi_q     <= '1;
      oeb_q    <= '1;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_q    <= go;
      held_q   <= held_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      settle_q <= settle_d;
      nsamp_q  <= nsamp_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      oeb_q    <= {hi_q, lo_q};
      start_q  <= start_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign start_o   = start_q;
  assign abort_o   = abort_q;
  assign irq_en_o  = irq_en_q;
  assign settle_o  = settle_q;
  assign nsamp_o   = nsamp_q;
  assign oeb_o     = oeb_q;
  assign done_o    = done_q;

endmodule

// File: rtl/msig_seq_ctrl.sv
// Mixed-signal power-up/settle/sample/power-down sequencer
// with comparator sample counting and done interrupt.
module msig_seq_ctrl
  import msig_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          SETTLE_W   = 16,
  parameter int          SAMPLE_DIV = 4,
  parameter int          IO_PADS    = 38
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               active,
  input  logic               cmp_i,
  output logic               bias_en_o,
  output logic               core_en_o,
  output logic               sample_o,
  output logic [IO_PADS-1:0] io_oeb_o,
  output logic               irq_o
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SAMPLE_DIV - 1);

  logic                start, abort, irq_en, done, busy;
  logic [SETTLE_W-1:0] settle;
  logic [7:0]          nsamp;
  logic                done_set, done_clr;
  logic                stop, cnt_zero, fire;

  logic                cmp_m_q, cmp_s_q;
  logic [2:0]          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [7:0]          scnt_q, scnt_d;
  logic [7:0]          nlat_q, nlat_d;
  logic [8:0]          result_q, result_d;
  logic                shut2_q, shut2_d;

  msig_wb_regs #(
    .ADDR_BASE (ADDR_BASE),
    .SETTLE_W  (SETTLE_W),
    .IO_PADS   (IO_PADS)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .state_i    (state_q),
    .busy_i     (busy),
    .done_set_i (done_set),
    .done_clr_i (done_clr),
    .result_i   (result_q),
    .start_o    (start),
    .abort_o    (abort),
    .irq_en_o   (irq_en),
    .settle_o   (settle),
    .nsamp_o    (nsamp),
    .oeb_o      (io_oeb_o),
    .done_o     (done)
  );

  assign busy     = state_q != ST_IDLE;
  assign stop     = abort | ~active;
  assign cnt_zero = cnt_q == '0;
  assign fire     = (state_q == ST_SAMPLE)
                  & (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    scnt_d   = scnt_q;
    nlat_d   = nlat_q;
    result_d = result_q;
    shut2_d  = 1'b0;
    done_set = 1'b0;
    done_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start && active) begin
        cnt_d    = settle;
        result_d = '0;
        done_clr = 1'b1;
        state_d  = ST_BIAS;
      end
      ST_BIAS:
        if (stop) state_d = ST_SHUT;
        else if (cnt_zero) begin
          cnt_d   = settle;
          state_d = ST_ENABLE;
        end else cnt_d = cnt_q - SETTLE_W'(1);
      ST_ENABLE:
        if (stop) state_d = ST_SHUT;
        else if (cnt_zero) begin
          div_d  = '0;
          scnt_d = '0;
          nlat_d = nsamp;
          state_d = (nsamp == '0) ? ST_DONE : ST_SAMPLE;
        end else cnt_d = cnt_q - SETTLE_W'(1);
      ST_SAMPLE: begin
        div_d = fire ? '0 : div_q + DIV_W'(1);
        if (fire) begin
          scnt_d = scnt_q + 8'd1;
          if (result_q != 9'h1FF)
            result_d = result_q + {8'd0, cmp_s_q};
        end
        if (stop) state_d = ST_SHUT;
        else if (fire && scnt_d == nlat_q)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_SHUT:
        if (shut2_q) state_d = ST_IDLE;
        else shut2_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmp_m_q  <= 1'b0;
      cmp_s_q  <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      scnt_q   <= '0;
      nlat_q   <= '0;
      result_q <= '0;
      shut2_q  <= 1'b0;
    end else begin
      cmp_m_q  <= cmp_i;
      cmp_s_q  <= cmp_m_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      scnt_q   <= scnt_d;
      nlat_q   <= nlat_d;
      result_q <= result_d;
      shut2_q  <= shut2_d;
    end
  end

  // enables decode straight from state so reset drops them at once
  assign bias_en_o = (state_q == ST_BIAS)
                   | (state_q == ST_ENABLE)
                   | (state_q == ST_SAMPLE)
                   | ((state_q == ST_SHUT) & ~shut2_q);
  assign core_en_o = (state_q == ST_ENABLE)
                   | (state_q == ST_SAMPLE);
  assign sample_o  = fire;
  assign irq_o     = done & irq_en;

endmodule

// File: tb/tb_msig_seq_ctrl.sv
// Self-checking bench for msig_seq_ctrl: traces the enables
// and sample strobes and checks them against sequence rules.
module tb_msig_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int DIV = 4;

  logic        clk, rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic        active, cmp_i;
  logic        bias, core, samp, irq;
  logic [37:0] oeb;

  int tests, fails;

  bit   mon_en, cmp_rand;
  logic cmp_fix;
  bit   q_bias[$], q_core[$], q_samp[$], q_cmp[$];

  msig_seq_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .active    (active),
    .cmp_i     (cmp_i),
    .bias_en_o (bias),
    .core_en_o (core),
    .sample_o  (samp),
    .io_oeb_o  (oeb),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  // trace index i holds outputs seen and cmp_i driven at negedge i
  always @(negedge clk) begin
    if (mon_en) begin
      q_bias.push_back(bias);
      q_core.push_back(core);
      q_samp.push_back(samp);
    end
    cmp_i = cmp_rand ? ($urandom_range(0, 1) == 1) : cmp_fix;
    if (mon_en) q_cmp.push_back(cmp_i);
  end

  task automatic q_clear();
    q_bias.delete();
    q_core.delete();
    q_samp.delete();
    q_cmp.delete();
  endtask

  task automatic wb_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; adr = a; dat = d; sel = s;
    do begin @(negedge clk); n++; end
    while (!ack && n < 8);
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL wr_ack adr=%h got=%b need=1", a, ack);
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wb_read(input logic [31:0] a,
                         output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = a; sel = 4'hF;
    do begin @(negedge clk); n++; end
    while (!ack && n < 8);
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL rd_ack adr=%h got=%b need=1", a, ack);
    end
    d = rdat;
    stb = 0; cyc = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1;
    repeat (2) @(negedge clk);
    tests++;
    if (oeb !== 38'h3F_FFFF_FFFF || bias !== 0 ||
        core !== 0 || samp !== 0 || ack !== 0 ||
        irq !== 0) begin
      fails++;
      $display("FAIL reset_outs oeb=%h b=%b c=%b s=%b a=%b i=%b",
               oeb, bias, core, samp, ack, irq);
    end
    rst = 0;
    wb_read(BASE + 32'h0C, r);
    tests++;
    if (r !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL reset_oeb_lo got=%h need=ffffffff", r);
    end
    wb_read(BASE + 32'h04, r);
    tests++;
    if (r !== 0) begin
      fails++;
      $display("FAIL reset_settle got=%h need=0", r);
    end
    wb_read(BASE + 32'h08, r);
    tests++;
    if (r !== 0) begin
      fails++;
      $display("FAIL reset_nsamp got=%h need=0", r);
    end
  endtask

  task automatic test_oeb();
    logic [31:0] r;
    int n;
    wb_write(BASE + 32'h0C, 32'h0000_00F0, 4'b0001);
    tests++;
    if (oeb !== 38'h3F_FFFF_FFFF) begin
      fails++;
      $display("FAIL oeb_early got=%h need=3fffffffff", oeb);
    end
    @(negedge clk);
    tests++;
    if (oeb !== 38'h3F_FFFF_FFF0) begin
      fails++;
      $display("FAIL oeb_byte0 got=%h need=3ffffffff0", oeb);
    end
    wb_write(BASE + 32'h10, 32'hFFFF_FF15, 4'hF);
    repeat (2) @(negedge clk);
    tests++;
    if (oeb !== 38'h15_FFFF_FFF0) begin
      fails++;
      $display("FAIL oeb_hi got=%h need=15fffffff0", oeb);
    end
    wb_read(BASE + 32'h10, r);
    tests++;
    if (r !== 32'h15) begin
      fails++;
      $display("FAIL oeb_hi_rd got=%h need=15", r);
    end
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; adr = 32'h3001_0000;
    dat = 32'h0; sel = 4'hF;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) n++;
    end
    stb = 0; cyc = 0; we = 0;
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL miss_ack got=%0d acks need=0", n);
    end
  endtask

  task automatic test_wb_misc();
    logic [31:0] r;
    int n;
    wb_read(BASE + 32'h1C, r);
    tests++;
    if (r !== 0) begin
      fails++;
      $display("FAIL unmapped_rd got=%h need=0", r);
    end
    wb_write(BASE + 32'h14, 32'hFFFF_FFDF, 4'hF);
    wb_read(BASE + 32'h14, r);
    tests++;
    if (r !== 0) begin
      fails++;
      $display("FAIL status_ro got=%h need=0", r);
    end
    wb_write(BASE + 32'h08, 32'h0000_005A, 4'hF);
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = BASE + 32'h08; sel = 4'hF;
    @(negedge clk);
    tests++;
    if (ack !== 1'b1 || rdat !== 32'h5A) begin
      fails++;
      $display("FAIL ack_first got=%b/%h need=1/5a", ack, rdat);
    end
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) n++;
    end
    stb = 0; cyc = 0;
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL ack_held got=%0d extra need=0", n);
    end
  endtask

  task automatic test_sequence();
    int s, n, ie, nb, nc, np, fb, fc, fp, prev, er;
    bit gap_ok;
    logic [31:0] r;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        s = 3; n = 4; ie = 0; cmp_rand = 0; cmp_fix = 1;
      end else begin
        s = $urandom_range(0, 6);
        n = $urandom_range(0, 6);
        ie = $urandom_range(0, 1);
        cmp_rand = 1;
      end
      wb_write(BASE + 32'h04, 32'(s), 4'hF);
      wb_write(BASE + 32'h08, 32'(n), 4'hF);
      q_clear();
      mon_en = 1;
      wb_write(BASE, 32'(ie * 4 + 1), 4'hF);
      repeat (2 * (s + 1) + DIV * n + 8) @(negedge clk);
      mon_en = 0;
      nb = 0; nc = 0; np = 0; er = 0;
      fb = -1; fc = -1; fp = -1; prev = -1; gap_ok = 1;
      for (int i = 0; i < q_bias.size(); i++) begin
        if (q_bias[i]) begin nb++; if (fb < 0) fb = i; end
        if (q_core[i]) begin nc++; if (fc < 0) fc = i; end
        if (q_samp[i]) begin
          np++;
          if (fp < 0) fp = i;
          if (prev >= 0 && i - prev != DIV) gap_ok = 0;
          prev = i;
          if (i >= 2 && q_cmp[i-2]) er++;
        end
      end
      tests++;
      if (nb != 2 * (s + 1) + DIV * n ||
          nc != (s + 1) + DIV * n) begin
        fails++;
        $display("FAIL seq_len it=%0d bias=%0d core=%0d need=%0d/%0d",
                 it, nb, nc, 2 * (s + 1) + DIV * n,
                 (s + 1) + DIV * n);
      end
      tests++;
      if (fc - fb != s + 1) begin
        fails++;
        $display("FAIL seq_bias_only it=%0d got=%0d need=%0d",
                 it, fc - fb, s + 1);
      end
      tests++;
      if (np != n || !gap_ok ||
          (n > 0 && fp - fc != s + DIV)) begin
        fails++;
        $display("FAIL seq_pulses it=%0d n=%0d gap=%b off=%0d need=%0d/1/%0d",
                 it, np, gap_ok, fp - fc, n, s + DIV);
      end
      wb_read(BASE + 32'h18, r);
      tests++;
      if (r !== 32'(er)) begin
        fails++;
        $display("FAIL seq_result it=%0d got=%0d need=%0d",
                 it, r, er);
      end
      wb_read(BASE + 32'h14, r);
      tests++;
      if (r !== 32'h20 || irq !== ie[0]) begin
        fails++;
        $display("FAIL seq_done it=%0d st=%h irq=%b need=20/%0d",
                 it, r, irq, ie);
      end
    end
    cmp_rand = 0;
  endtask

  task automatic test_irq();
    logic [31:0] r;
    int nc;
    wb_write(BASE + 32'h04, 32'd2, 4'hF);
    wb_write(BASE + 32'h08, 32'd0, 4'hF);
    q_clear();
    mon_en = 1;
    wb_write(BASE, 32'h5, 4'hF);
    repeat (12) @(negedge clk);
    mon_en = 0;
    nc = 0;
    foreach (q_core[i]) if (q_core[i]) nc++;
    tests++;
    if (nc != 3) begin
      fails++;
      $display("FAIL irq_core_len got=%0d need=3", nc);
    end
    wb_read(BASE + 32'h18, r);
    tests++;
    if (r !== 0 || irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_set res=%0d irq=%b need=0/1", r, irq);
    end
    wb_write(BASE + 32'h14, 32'h20, 4'hF);
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear got=%b need=0", irq);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int p, k, lc;
    for (int mode = 0; mode < 2; mode++) begin
      cmp_fix = 1;
      wb_write(BASE + 32'h04, 32'd1, 4'hF);
      wb_write(BASE + 32'h08, 32'd5, 4'hF);
      q_clear();
      mon_en = 1;
      wb_write(BASE, 32'h1, 4'hF);
      p = 0;
      k = 0;
      while (p < 2 && k < 60) begin
        @(negedge clk);
        k++;
        if (samp) p++;
      end
      tests++;
      if (p != 2) begin
        fails++;
        $display("FAIL abort_wait mode=%0d pulses=%0d need=2",
                 mode, p);
      end
      if (mode == 0) wb_write(BASE, 32'h2, 4'hF);
      else active = 0;
      repeat (8) @(negedge clk);
      mon_en = 0;
      active = 1;
      p = 0;
      lc = -1;
      foreach (q_core[i]) begin
        if (q_core[i]) lc = i;
        if (q_samp[i]) p++;
      end
      tests++;
      if (p != 2 || lc < 0 || lc + 2 >= q_bias.size() ||
          q_bias[lc+1] != 1 || q_core[lc+1] != 0 ||
          q_bias[lc+2] != 0) begin
        fails++;
        $display("FAIL abort_shut mode=%0d pulses=%0d lc=%0d need=2 and core-then-bias drop",
                 mode, p, lc);
      end
      wb_read(BASE + 32'h18, r);
      tests++;
      if (r !== 32'd2) begin
        fails++;
        $display("FAIL abort_result mode=%0d got=%0d need=2",
                 mode, r);
      end
      wb_read(BASE + 32'h14, r);
      tests++;
      if (r !== 0) begin
        fails++;
        $display("FAIL abort_status mode=%0d got=%h need=0",
                 mode, r);
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] r;
    int nb, nc, np;
    wb_write(BASE + 32'h04, 32'd5, 4'hF);
    wb_write(BASE + 32'h08, 32'd2, 4'hF);
    q_clear();
    mon_en = 1;
    wb_write(BASE, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    wb_write(BASE, 32'h1, 4'hF);
    repeat (30) @(negedge clk);
    mon_en = 0;
    nb = 0; nc = 0; np = 0;
    foreach (q_bias[i]) begin
      nb += q_bias[i];
      nc += q_core[i];
      np += q_samp[i];
    end
    tests++;
    if (nb != 20 || nc != 14 || np != 2) begin
      fails++;
      $display("FAIL busy_start b=%0d c=%0d p=%0d need=20/14/2",
               nb, nc, np);
    end
    for (int m = 0; m < 2; m++) begin
      q_clear();
      mon_en = 1;
      if (m == 0) wb_write(BASE, 32'h3, 4'hF);
      else begin
        active = 0;
        wb_write(BASE, 32'h1, 4'hF);
      end
      repeat (6) @(negedge clk);
      mon_en = 0;
      active = 1;
      nb = 0;
      foreach (q_bias[i]) nb += q_bias[i];
      wb_read(BASE + 32'h14, r);
      tests++;
      if (nb != 0 || r[4] !== 1'b0) begin
        fails++;
        $display("FAIL no_start m=%0d bias=%0d busy=%b need=0/0",
                 m, nb, r[4]);
      end
    end
  endtask

  task automatic test_async_reset();
    wb_write(BASE + 32'h04, 32'd9, 4'hF);
    wb_write(BASE, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    tests++;
    if (bias !== 0 || core !== 0 || oeb !== 38'h3F_FFFF_FFFF) begin
      fails++;
      $display("FAIL async_rst b=%b c=%b oeb=%h need=0/0/3fffffffff",
               bias, core, oeb);
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    clk = 0; rst = 1;
    stb = 0; cyc = 0; we = 0; sel = 0; dat = 0; adr = 0;
    active = 1; cmp_fix = 0; cmp_rand = 0; cmp_i = 0;
    mon_en = 0;
    tests = 0; fails = 0;
    test_reset();
    test_oeb();
    test_wb_misc();
    test_sequence();
    test_irq();
    test_abort();
    test_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
